// File: rtl/inst_sram_like_to_axi.sv
// Instruction-side sram_like to AXI3 read bridge: one outstanding single-beat read.
// Define INST_AXI_RSP_REG_EN to register the R beat before returning it to the CPU.
module inst_sram_like_to_axi #(
    parameter int unsigned AXI_ID   = 0,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [31:0]         inst_addr,
    input  logic [31:0]         inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [31:0]         inst_rdata,
    output logic                inst_bus_err,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

`ifdef INST_AXI_RSP_REG_EN
    typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;
    logic [31:0] rsp_data_q;
`else
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
`endif

    state_t      state;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        bus_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            araddr_q  <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef INST_AXI_RSP_REG_EN
            rsp_data_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req) begin
                        araddr_q  <= inst_addr;
                        arsize_q  <= {1'b0, inst_size};
                        arvalid_q <= 1'b1;
                        state     <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= R;
                    end
                end
                R: begin
                    // single beat: rlast/rid are not needed to complete
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (rresp != 2'b00) begin
                            bus_err_q <= 1'b1;
                        end
`ifdef INST_AXI_RSP_REG_EN
                        rsp_data_q <= rdata;
                        state      <= RSP;
`else
                        state      <= IDLE;
`endif
                    end
                end
`ifdef INST_AXI_RSP_REG_EN
                RSP: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign inst_addr_ok = rst && (state == IDLE) && inst_req;

`ifdef INST_AXI_RSP_REG_EN
    assign inst_data_ok = (state == RSP);
    assign inst_rdata   = inst_data_ok ? rsp_data_q : '0;
`else
    assign inst_data_ok = (state == R) && rvalid;
    assign inst_rdata   = inst_data_ok ? rdata : '0;
`endif

    assign inst_bus_err = bus_err_q;
    assign arid         = ID_WIDTH'(AXI_ID);
    assign araddr       = araddr_q;
    assign arlen        = 4'd0;
    assign arsize       = arsize_q;
    assign arburst      = 2'b01;
    assign arlock       = 2'b00;
    assign arcache      = 4'd0;
    assign arprot       = 3'd0;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;

    logic unused_ok;
    assign unused_ok = ^{inst_wr, inst_wdata, rid, rlast, 1'b0};

endmodule

// File: tb/tb_inst_sram_like_to_axi.sv
// Randomized self-checking bench for inst_sram_like_to_axi; follows INST_AXI_RSP_REG_EN.
module tb_inst_sram_like_to_axi;

`ifdef INST_AXI_RSP_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        inst_bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_passed = 0;
    bit err_model = 1'b0;

    inst_sram_like_to_axi #(.AXI_ID(0), .ID_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_bus_err(inst_bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus driver and observer for one fetch; the AXI slave honours the
    // requested AR stall (arw cycles) and R delay (rw cycles after the AR handshake).
    task automatic run_fetch(
        input  logic [31:0] a, input logic [1:0] sz, input logic wr,
        input  int unsigned arw, input int unsigned rw,
        input  logic [31:0] d, input logic [1:0] rs, input bit keep,
        output int aok_first, output int n_aok, output int arv_first, output bit ar_stable,
        output logic [31:0] got_addr, output logic [2:0] got_size,
        output int rready_cnt, output int data_cyc, output int n_data,
        output logic [31:0] got_data, output int n_stray);
        int unsigned ar_cnt, r_cnt;
        bit ar_done, r_done, done;
        int budget;
        logic [31:0] rnd;
        aok_first = -1; n_aok = 0; arv_first = -1; ar_stable = 1'b1;
        got_addr = '0; got_size = '0; rready_cnt = 0; data_cyc = -1;
        n_data = 0; got_data = '0; n_stray = 0;
        ar_cnt = 0; r_cnt = 0; ar_done = 1'b0; r_done = 1'b0; done = 1'b0;
        budget = 12 + int'(arw) + int'(rw);
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            inst_req   = (cyc == 0) || keep;
            inst_addr  = a;
            inst_size  = sz;
            inst_wr    = wr;
            inst_wdata = $urandom;
            arready    = !ar_done && (ar_cnt >= arw);
            rnd        = $urandom;
            rid        = rnd[3:0];
            if (ar_done && !r_done) begin
                rvalid = (r_cnt >= rw);
                rdata  = rvalid ? d : $urandom;
                rresp  = rvalid ? rs : 2'b11;
                rlast  = rvalid;
            end else begin
                rvalid = rnd[4];
                rdata  = $urandom;
                rresp  = rnd[6:5];
                rlast  = rnd[7];
            end
            @(negedge clk);
            if (inst_addr_ok) begin
                n_aok++;
                if (aok_first < 0) aok_first = cyc;
            end
            if (arvalid) begin
                if (arv_first < 0) begin
                    arv_first = cyc;
                    got_addr  = araddr;
                    got_size  = arsize;
                end else if (araddr !== got_addr || arsize !== got_size) begin
                    ar_stable = 1'b0;
                end
                if (arready) ar_done = 1'b1;
                else ar_cnt++;
            end
            if (rready) begin
                rready_cnt++;
                if (rvalid) r_done = 1'b1;
                else r_cnt++;
            end
            if (inst_data_ok) begin
                n_data++;
                data_cyc = cyc;
                got_data = inst_rdata;
                done     = 1'b1;
            end else if (inst_rdata !== 32'd0) begin
                n_stray++;
            end
            @(posedge clk); #1;
        end
        if (!keep) inst_req = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        if (rs != 2'b00 && n_data > 0) err_model = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'b10;
        inst_addr = 32'h1234_5678; inst_wdata = '0; arready = 1'b1;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'b10; rlast = 1'b1; rid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({arvalid, rready, inst_addr_ok, inst_data_ok, inst_bus_err} !== 5'b0)
            $display("FAIL reset_ctrl: arvalid/rready/addr_ok/data_ok/bus_err=%b required 00000",
                     {arvalid, rready, inst_addr_ok, inst_data_ok, inst_bus_err});
        else n_passed++;
        n_checks++;
        if (inst_rdata !== 32'd0) $display("FAIL reset_rdata: got %h required 0", inst_rdata);
        else n_passed++;
        n_checks++;
        if (araddr !== 32'd0 || arsize !== 3'd0)
            $display("FAIL reset_ar: araddr=%h arsize=%0d required 0/0", araddr, arsize);
        else n_passed++;
        @(posedge clk); #1;
        rst = 1'b1; inst_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
        err_model = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        run_fetch(32'hBFC0_0000, 2'b10, 1'b0, 0, 0, 32'h3C08_1234, 2'b00, 1'b0,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        n_checks++;
        if (aok !== 0) $display("FAIL single_addr_ok_cycle: got %0d required 0", aok);
        else n_passed++;
        n_checks++;
        if (arv !== 1) $display("FAIL single_arvalid_cycle: got %0d required 1", arv);
        else n_passed++;
        n_checks++;
        if (ga !== 32'hBFC0_0000 || gs !== 3'b010)
            $display("FAIL single_ar: araddr=%h arsize=%b required bfc00000/010", ga, gs);
        else n_passed++;
        n_checks++;
        if (dc !== 2 + LAT || nd !== 1)
            $display("FAIL single_data_ok: cycle=%0d count=%0d required %0d/1", dc, nd, 2 + LAT);
        else n_passed++;
        n_checks++;
        if (gd !== 32'h3C08_1234) $display("FAIL single_rdata: got %h required 3c081234", gd);
        else n_passed++;
        n_checks++;
        if ({arid, arlen, arburst, arlock, arcache, arprot} !== {4'd0, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0})
            $display("FAIL const_ar: id=%0d len=%0d burst=%b lock=%b cache=%0d prot=%0d",
                     arid, arlen, arburst, arlock, arcache, arprot);
        else n_passed++;
    endtask

    task automatic test_ar_backpressure();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        run_fetch(32'h0000_1000, 2'b10, 1'b0, 5, 0, 32'hA5A5_0001, 2'b00, 1'b1,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        inst_req = 1'b0;
        n_checks++;
        if (!st || ga !== 32'h0000_1000)
            $display("FAIL arbp_stable: stable=%0d araddr=%h required 1/00001000", st, ga);
        else n_passed++;
        n_checks++;
        if (naok !== 1) $display("FAIL arbp_addr_ok_count: got %0d required 1", naok);
        else n_passed++;
        n_checks++;
        if (dc !== 7 + LAT || nd !== 1 || gd !== 32'hA5A5_0001)
            $display("FAIL arbp_complete: cycle=%0d count=%0d data=%h required %0d/1/a5a50001",
                     dc, nd, gd, 7 + LAT);
        else n_passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_r_delay();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        run_fetch(32'h0000_2000, 2'b10, 1'b0, 0, 10, 32'h1357_9BDF, 2'b00, 1'b0,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        n_checks++;
        if (rrc !== 11) $display("FAIL rdelay_rready_cycles: got %0d required 11", rrc);
        else n_passed++;
        n_checks++;
        if (nd !== 1 || dc !== 12 + LAT || gd !== 32'h1357_9BDF)
            $display("FAIL rdelay_data: count=%0d cycle=%0d data=%h required 1/%0d/13579bdf",
                     nd, dc, gd, 12 + LAT);
        else n_passed++;
        n_checks++;
        if (ns !== 0) $display("FAIL rdelay_rdata_idle_zero: nonzero cycles=%0d required 0", ns);
        else n_passed++;
    endtask

    task automatic test_back_to_back();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        for (int i = 0; i < 3; i++) begin
            run_fetch(32'(4 * i), 2'b10, 1'b0, 0, 0, 32'hC0DE_0000 + 32'(i), 2'b00, 1'b1,
                      aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
            n_checks++;
            if (aok !== 0 || naok !== 1)
                $display("FAIL b2b_addr_ok[%0d]: first=%0d count=%0d required 0/1", i, aok, naok);
            else n_passed++;
            n_checks++;
            if (ga !== 32'(4 * i) || gd !== 32'hC0DE_0000 + 32'(i))
                $display("FAIL b2b_addr_data[%0d]: araddr=%h data=%h required %h/%h",
                         i, ga, gd, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            else n_passed++;
        end
        inst_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_error_resp();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        run_fetch(32'h0000_3000, 2'b10, 1'b0, 1, 2, 32'hDEAD_BEEF, 2'b10, 1'b0,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        n_checks++;
        if (nd !== 1 || gd !== 32'hDEAD_BEEF)
            $display("FAIL err_data: count=%0d data=%h required 1/deadbeef", nd, gd);
        else n_passed++;
        n_checks++;
        if (inst_bus_err !== 1'b1) $display("FAIL err_flag_set: got %b required 1", inst_bus_err);
        else n_passed++;
        run_fetch(32'h0000_3004, 2'b10, 1'b0, 0, 0, 32'h0000_0042, 2'b00, 1'b0,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        n_checks++;
        if (inst_bus_err !== 1'b1 || gd !== 32'h0000_0042)
            $display("FAIL err_flag_sticky: bus_err=%b data=%h required 1/00000042", inst_bus_err, gd);
        else n_passed++;
    endtask

    task automatic test_async_reset();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd;
        logic [2:0] gs;
        inst_req = 1'b1; inst_addr = 32'h0000_4000; inst_size = 2'b10; rvalid = 1'b0;
        @(posedge clk); #1;
        inst_req = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        #2;
        rvalid = 1'b1; rdata = 32'h7777_8888; rresp = 2'b00;
        #1;
        n_checks++;
        if (rready !== 1'b1 || inst_data_ok !== 1'b1 || inst_bus_err !== err_model)
            $display("FAIL areset_pre: rready=%b data_ok=%b bus_err=%b required 1/1/%b",
                     rready, inst_data_ok, inst_bus_err, err_model);
        else n_passed++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({arvalid, rready, inst_data_ok, inst_bus_err} !== 4'b0)
            $display("FAIL areset_drop: arvalid/rready/data_ok/bus_err=%b required 0000",
                     {arvalid, rready, inst_data_ok, inst_bus_err});
        else n_passed++;
        err_model = 1'b0;
        rvalid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        run_fetch(32'h0000_5000, 2'b10, 1'b0, 0, 1, 32'h2468_ACE0, 2'b00, 1'b0,
                  aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
        n_checks++;
        if (aok !== 0 || ga !== 32'h0000_5000 || gd !== 32'h2468_ACE0 || nd !== 1)
            $display("FAIL areset_next: aok=%0d addr=%h data=%h count=%0d required 0/00005000/2468ace0/1",
                     aok, ga, gd, nd);
        else n_passed++;
    endtask

    task automatic test_random();
        int aok, naok, arv, rrc, dc, nd, ns;
        bit st;
        logic [31:0] ga, gd, a, d, t;
        logic [2:0] gs;
        logic [1:0] sz, rs;
        int unsigned arw, rw;
        bit keep, wr;
        for (int i = 0; i < 25; i++) begin
            t    = $urandom;
            a    = {t[31:2], 2'b00};
            d    = $urandom;
            sz   = 2'($urandom_range(0, 2));
            arw  = $urandom_range(0, 4);
            rw   = $urandom_range(0, 4);
            rs   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            keep = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            run_fetch(a, sz, wr, arw, rw, d, rs, keep,
                      aok, naok, arv, st, ga, gs, rrc, dc, nd, gd, ns);
            n_checks++;
            if (aok !== 0 || naok !== 1 || arv !== 1)
                $display("FAIL rand_accept[%0d]: aok=%0d naok=%0d arv=%0d required 0/1/1", i, aok, naok, arv);
            else n_passed++;
            n_checks++;
            if (ga !== a || gs !== {1'b0, sz} || !st)
                $display("FAIL rand_ar[%0d]: araddr=%h arsize=%b stable=%0d required %h/%b/1",
                         i, ga, gs, st, a, {1'b0, sz});
            else n_passed++;
            n_checks++;
            if (nd !== 1 || dc !== 2 + int'(arw) + int'(rw) + LAT || gd !== d)
                $display("FAIL rand_data[%0d]: count=%0d cycle=%0d data=%h required 1/%0d/%h",
                         i, nd, dc, gd, 2 + int'(arw) + int'(rw) + LAT, d);
            else n_passed++;
            n_checks++;
            if (rrc !== int'(rw) + 1 || ns !== 0)
                $display("FAIL rand_rready[%0d]: rready_cycles=%0d stray=%0d required %0d/0",
                         i, rrc, ns, int'(rw) + 1);
            else n_passed++;
            n_checks++;
            if (inst_bus_err !== err_model)
                $display("FAIL rand_bus_err[%0d]: got %b required %b", i, inst_bus_err, err_model);
            else n_passed++;
        end
        inst_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_ar_backpressure();
        test_r_delay();
        test_back_to_back();
        test_error_resp();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_sram_like_to_axi.md
Name: inst_sram_like_to_axi

Overview:
- Read-only bridge from the CPU instruction-side sram_like bus to an AXI3 read master port.
- Directly downstream of the instruction sram-to-sram_like adapter. Consumes its inst_req/inst_addr/inst_size. Produces inst_addr_ok/inst_data_ok/inst_rdata.
- One outstanding transaction, single-beat reads. Every accepted request returns exactly one data_ok, including requests the upstream later discards after a flush.

Parameters:
- AXI_ID, 0, value driven on arid for every request.
- ID_WIDTH, 4, width of arid/rid.

Ports:
- clk  input  1  the only clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- inst_req  input  1  sram_like request.
- inst_wr  input  1  write flag; must be 0 (instruction side is read-only).
- inst_size  input  2  log2 of bytes (2'b10 = word).
- inst_addr  input  32  byte address.
- inst_wdata  input  32  unused.
- inst_addr_ok  output  1  request accepted this cycle.
- inst_data_ok  output  1  read data valid this cycle.
- inst_rdata  output  32  read data.
- inst_bus_err  output  1  sticky: a read response had rresp != 2'b00.
- arid  output  ID_WIDTH  read address ID.
- araddr  output  32  read address.
- arlen  output  4  burst length field.
- arsize  output  3  transfer size.
- arburst  output  2  burst type.
- arlock  output  2  lock type.
- arcache  output  4  cache attributes.
- arprot  output  3  protection attributes.
- arvalid  output  1  AR channel valid.
- arready  input  1  AR channel ready.
- rid  input  ID_WIDTH  read response ID.
- rdata  input  32  read data.
- rresp  input  2  read response code.
- rlast  input  1  last beat of burst.
- rvalid  input  1  R channel valid.
- rready  output  1  R channel ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - arvalid=0, rready=0, inst_addr_ok=0, inst_data_ok=0, inst_rdata=0, inst_bus_err=0.
  - araddr/arsize registers clear to 0.
- Constant AR fields: arid=AXI_ID, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0.
- States are IDLE, AR and R.
- IDLE:
  - inst_addr_ok = inst_req (combinational).
  - On inst_req=1: latch araddr<=inst_addr and arsize<={1'b0,inst_size}, then go to AR.
- AR:
  - arvalid=1; AR fields stay stable until the handshake.
  - On arready=1: go to R.
  - inst_addr_ok=0 in this state.
- R:
  - rready=1.
  - On rvalid=1: inst_data_ok=1 and inst_rdata=rdata in the same cycle, then go to IDLE.
  - rlast and rid are not required for completion (arlen=0 means a single beat).
  - inst_addr_ok=0 in this state.
- inst_rdata is 0 whenever inst_data_ok=0.
- No back-to-back acceptance:
  - A new request is accepted only in IDLE, i.e. at the earliest the cycle after data_ok.
  - An inst_req held high through completion is accepted in the next IDLE cycle.
- Minimum latency:
  - inst_req at cycle 0 gives addr_ok at cycle 0 and arvalid at cycle 1.
  - arready at cycle 1 gives R at cycle 2.
  - rvalid at cycle 2 gives data_ok at cycle 2.
- Flush interaction:
  - The bridge has no flush input; a transaction, once accepted, always completes.
  - The upstream is responsible for discarding the returned data.
- inst_bus_err:
  - Set on an R handshake with rresp != 0.
  - Cleared only by reset.
  - Data is still returned with data_ok.
- inst_wr=1: the request is still handled as a read.
- rvalid seen in IDLE or AR: ignored; rready=0 there.
- Reset asserted mid-transaction: the bridge aborts immediately. The AXI slave shares the reset, so no orphaned response is expected.

Optional Feature:
- Macro: INST_AXI_RSP_REG_EN.
- When defined:
  - The R beat is captured into a register on the handshake; state moves R->RSP.
  - In RSP: inst_data_ok=1 and inst_rdata=the registered data for exactly one cycle, then IDLE.
  - Adds 1 cycle of latency and removes the rdata-to-CPU combinational path.
  - inst_bus_err is updated at capture.
- When undefined: same-cycle pass-through as described in Behaviour.

Test Plan:
- Single fetch: inst_req=1 with addr 0xBFC00000 in IDLE, arready=1 next cycle, rvalid with rdata 0x3C081234 one cycle later.
  - Required: addr_ok at cycle 0; arvalid at cycle 1 with araddr=0xBFC00000, arsize=3'b010, arlen=0; data_ok=1 with rdata=0x3C081234 at cycle 2 (cycle 3 with INST_AXI_RSP_REG_EN).
- AR backpressure: arready held 0 for 5 cycles.
  - Required: arvalid stays 1 with araddr stable; no data_ok; addr_ok=0 throughout; completion after arready.
- R delay: rvalid delayed 10 cycles after the AR handshake.
  - Required: rready=1 for all 10 cycles; exactly one data_ok pulse.
- Back-to-back: inst_req held 1 across 3 fetches to 0x0, 0x4, 0x8 with immediate arready/rvalid.
  - Required: three addr_ok pulses, each in the IDLE cycle after the previous data_ok; araddr sequence 0x0, 0x4, 0x8.
- Error response: rresp=2'b10 with rdata 0xDEADBEEF.
  - Required: data_ok with 0xDEADBEEF; inst_bus_err=1 and stays 1 after a following OKAY read.
- Async reset: rst driven low mid-R (not on a clock edge).
  - Required: arvalid, rready, data_ok and inst_bus_err drop to 0 immediately; the next req after release is accepted in IDLE.
